alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, handshaked ALU for the CPU datapath; operand width is WIDTH; every result registered.
- Adds over the fixed 4-bit ALU: valid/ready flow control, status flags, variable-amount shifts and a multi-cycle shift-add multiplier.
- Sits between the operand register file and the accumulator/writeback stage; the control FSM issues ops and the writeback stage drains results.

Parameters:
- WIDTH, 8, operand width in bits (>=4, power of 2).
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL decodes as illegal.
- SHAMT_W, $clog2(WIDTH), derived localparam; shift-amount field width, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts operation this cycle.
- opcode  in  8  operation select; only [3:0] decoded, [7:4] must be 0.
- in_1  in  WIDTH  operand A.
- in_2  in  WIDTH  operand B / shift amount in [SHAMT_W-1:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- out  out  2*WIDTH  result; upper WIDTH bits are 0 except for MUL.
- flag_z, flag_n, flag_c, flag_v  out  1 each  zero / negative / carry-borrow / signed overflow.
- err  out  1  illegal opcode for the current result.
- busy  out  1  multiplier in progress.

Behaviour:
- Reset (async, rst_n=0): out=0, all flags=0, err=0, out_valid=0, busy=0, state IDLE. Reset mid-MUL aborts immediately; the partial product is discarded.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Opcodes 0..A:
  - 0 PASS A.
  - 1 ADD, 2 SUB (A-B), 3 NOT A, 4 OR, 5 AND, 6 XOR.
  - 7 SHL, 8 SHR logical, 9 SRA; shift amount = in_2[SHAMT_W-1:0].
  - A MUL: unsigned, full 2*WIDTH product.
  - B..F, any nonzero opcode[7:4], or A with MUL_EN=0: illegal.
- Single-cycle ops: accepted in cycle T -> out/flags registered, out_valid=1 in cycle T+1. Back-to-back issue gives 1 result/cycle while out_ready=1.
- MUL FSM:
  - IDLE -> MUL on accept; busy=1.
  - MUL runs WIDTH cycles of shift-add; in_ready=0 throughout.
  - Then -> IDLE with out_valid=1 in cycle T+1+WIDTH.
- Output hold: while out_valid && !out_ready, out, flags and err hold stable and in_ready=0. out_valid drops the cycle after handshake unless a new result is loaded on that same edge.
- Flags, computed on the low WIDTH bits (all 2*WIDTH bits for MUL):
  - z: result == 0.
  - n: MSB of low word (MSB of full product for MUL).
  - c: ADD carry-out; SUB borrow (A<B unsigned); shifts = last bit shifted out (0 when amount 0); all other ops 0.
  - v: signed overflow for ADD/SUB only; 0 for all other ops.
- Illegal opcode: completes as a single-cycle op; out=0, err=1, z=1, other flags 0.
- Shift amount 0: result = A, c=0. SRA replicates A[WIDTH-1].
- Wrap-around: ADD/SUB results modulo 2^WIDTH; no saturation.
- Operands are latched at accept; later changes on in_1/in_2/opcode have no effect on an in-flight MUL.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_PASS..OP_MUL;
  - state encoding (ST_IDLE, ST_MUL);
  - flag bit indices for the CPU status register.
- One sub-module, alu_mul_seq: WIDTH-cycle shift-add multiplier with start/done and an internal counter, instantiated only when MUL_EN=1 (generate).

Test Plan (WIDTH=8):
- ADD 0xFF+0x01, out_ready=1 -> out=0x0000, z=1, c=1, v=0, out_valid in cycle T+1.
- SUB 0x80-0x01 -> out=0x007F, v=1, c=0, n=0; SUB 0x01-0x02 -> out=0x00FF, c=1, n=1.
- MUL 0xFF*0xFF -> out=0xFE01, n=1, out_valid exactly in cycle T+9, in_ready=0 and busy=1 for cycles T+1..T+8.
- SRA 0x80 by 3 -> out=0x00F0, c=0; SHL 0x81 by 1 -> out=0x0002, c=1; opcode 0x2B -> out=0, err=1.
- Back-to-back 4 ADDs with out_ready=1 -> 4 results on 4 consecutive cycles. Then hold out_ready=0 for 3 cycles -> out stable, in_ready=0, no op accepted.
- rst_n low during MUL cycle 3 -> out_valid=0, busy=0 immediately. After release, in_ready=1 and a following ADD 2+3 -> out=0x0005.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and status-flag definitions for the ALU datapath.
package alu_pkg;
   localparam logic [3:0] OP_PASS = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_NOT  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_SRA  = 4'h9;
   localparam logic [3:0] OP_MUL  = 4'hA;

   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

   // Bit positions inside the CPU status register.
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;
   localparam int FLAG_W = 4;
endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles per op.
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam int CNT_W = $clog2(WIDTH);

   logic                 run;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc_next;
   logic [WIDTH-1:0]     mplier;

   // product is the accumulator after the current step, so the final sum is
   // available on the same edge that retires the last step.
   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign done     = run && (cnt == CNT_W'(WIDTH - 1));
   assign product  = acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 1'b0;
         cnt <= '0;
      end else if (start) begin
         run <= 1'b1;
         cnt <= '0;
      end else if (run) begin
         if (done) run <= 1'b0;
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
      end else if (run) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end
endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags and an optional multi-cycle multiplier.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           opcode,
   input  logic [WIDTH-1:0]     in_1,
   input  logic [WIDTH-1:0]     in_2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out,
   output logic                 flag_z,
   output logic                 flag_n,
   output logic                 flag_c,
   output logic                 flag_v,
   output logic                 err,
   output logic                 busy
);
   localparam int SHAMT_W = $clog2(WIDTH);

   function automatic logic [FLAG_W-1:0] pack_flags(input logic z, input logic n,
                                                    input logic c, input logic v);
      logic [FLAG_W-1:0] f;
      f         = '0;
      f[FLAG_Z] = z;
      f[FLAG_N] = n;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

   state_t state, state_next;

   logic [3:0]           op;
   logic [SHAMT_W-1:0]   shamt;
   logic                 illegal_p0, is_mul_p0, accept;
   logic [WIDTH-1:0]     res_p0;
   logic                 c_p0, v_p0;
   logic [WIDTH:0]       sum_ext, dif_ext, shl_ext, shr_ext;
   logic signed [WIDTH:0] sra_ext;

   logic [2*WIDTH-1:0]   res_p1;
   logic [FLAG_W-1:0]    flags_p1;
   logic                 err_p1, vld_p1;

   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_product;

   assign op         = opcode[3:0];
   assign shamt      = in_2[SHAMT_W-1:0];
   assign illegal_p0 = (|opcode[7:4]) || (op > OP_MUL) || ((op == OP_MUL) && (MUL_EN == 0));
   assign is_mul_p0  = !illegal_p0 && (op == OP_MUL);
   assign in_ready   = (state == ST_IDLE) && (!vld_p1 || out_ready);
   assign accept     = in_valid && in_ready;
   assign busy       = (state == ST_MUL);

   // Extended operands: the extra bit carries carry/borrow or the last bit shifted out.
   assign sum_ext = {1'b0, in_1} + {1'b0, in_2};
   assign dif_ext = {1'b0, in_1} - {1'b0, in_2};
   assign shl_ext = {1'b0, in_1} << shamt;
   assign shr_ext = {in_1, 1'b0} >> shamt;
   assign sra_ext = $signed({in_1, 1'b0}) >>> shamt;

   always_comb begin
      res_p0 = '0;
      c_p0   = 1'b0;
      v_p0   = 1'b0;
      if (!illegal_p0) begin
         case (op)
            OP_PASS: res_p0 = in_1;
            OP_ADD: begin
               res_p0 = sum_ext[WIDTH-1:0];
               c_p0   = sum_ext[WIDTH];
               v_p0   = (in_1[WIDTH-1] == in_2[WIDTH-1]) && (sum_ext[WIDTH-1] != in_1[WIDTH-1]);
            end
            OP_SUB: begin
               res_p0 = dif_ext[WIDTH-1:0];
               c_p0   = dif_ext[WIDTH];
               v_p0   = (in_1[WIDTH-1] != in_2[WIDTH-1]) && (dif_ext[WIDTH-1] != in_1[WIDTH-1]);
            end
            OP_NOT: res_p0 = ~in_1;
            OP_OR:  res_p0 = in_1 | in_2;
            OP_AND: res_p0 = in_1 & in_2;
            OP_XOR: res_p0 = in_1 ^ in_2;
            OP_SHL: begin
               res_p0 = shl_ext[WIDTH-1:0];
               c_p0   = shl_ext[WIDTH];
            end
            OP_SHR: begin
               res_p0 = shr_ext[WIDTH:1];
               c_p0   = shr_ext[0];
            end
            OP_SRA: begin
               res_p0 = sra_ext[WIDTH:1];
               c_p0   = sra_ext[0];
            end
            default: ;
         endcase
      end
   end

   generate
      if (MUL_EN != 0) begin : g_mul
         alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (accept && is_mul_p0),
            .a       (in_1),
            .b       (in_2),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept && is_mul_p0) state_next = ST_MUL;
         ST_MUL:  if (mul_done)            state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // ---- stage p0 -> p1: result register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_p1   <= '0;
         flags_p1 <= '0;
         err_p1   <= 1'b0;
         vld_p1   <= 1'b0;
      end else if (accept && !is_mul_p0) begin
         res_p1   <= {{WIDTH{1'b0}}, res_p0};
         flags_p1 <= pack_flags(res_p0 == '0, res_p0[WIDTH-1], c_p0, v_p0);
         err_p1   <= illegal_p0;
         vld_p1   <= 1'b1;
      end else if ((state == ST_MUL) && mul_done) begin
         res_p1   <= mul_product;
         flags_p1 <= pack_flags(mul_product == '0, mul_product[2*WIDTH-1], 1'b0, 1'b0);
         err_p1   <= 1'b0;
         vld_p1   <= 1'b1;
      end else if (out_ready) begin
         vld_p1   <= 1'b0;
      end
   end

   assign out       = res_p1;
   assign out_valid = vld_p1;
   assign err       = err_p1;
   assign flag_z    = flags_p1[FLAG_Z];
   assign flag_n    = flags_p1[FLAG_N];
   assign flag_c    = flags_p1[FLAG_C];
   assign flag_v    = flags_p1[FLAG_V];
endmodule
